// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: decode handshake, EX redirect and byte-wide memory read port.
// The master side belongs to if_fetch_unit and the slave side to its environment.
interface if_fetch_unit_if;
    logic        stall_i;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic        mem_grant_i;
    logic [7:0]  mem_din_i;
    logic [31:0] mem_a_o;
    logic        mem_rd_en_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    modport master (
        input  stall_i, jump_i, jump_addr_i, mem_grant_i, mem_din_i,
        output mem_a_o, mem_rd_en_o, pc_o, inst_o, inst_valid_o
    );

    modport slave (
        output stall_i, jump_i, jump_addr_i, mem_grant_i, mem_din_i,
        input  mem_a_o, mem_rd_en_o, pc_o, inst_o, inst_valid_o
    );
endinterface

// File: rtl/if_fetch_unit.sv
// RISC-V IF stage: assembles each instruction from four little-endian byte reads and holds it for decode.
// Optional direct-mapped one-word-per-line instruction cache enabled by defining ICACHE_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned ICACHE_LINES = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
    if_fetch_unit_if.master bus
);
    typedef enum logic {FETCH, HOLD} state_t;

    if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_bad_lines
        $error("ICACHE_LINES must be a power of two, at least 2");
    end

    state_t      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [2:0]  iss_q, iss_d;
    logic [1:0]  rcv_q, rcv_d;
    logic [23:0] buf_q, buf_d;
    logic        inflight_q, inflight_d;
    logic        discard_q, discard_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic        rd_en_q, rd_en_d;
    logic [31:0] a_q, a_d;
    logic        hit_q, hit_d;
    logic        issue;
    logic        enter;
    logic [31:0] cword;

    assign issue = rd_en_q & bus.mem_grant_i;

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        iss_d      = iss_q;
        rcv_d      = rcv_q;
        buf_d      = buf_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        valid_d    = valid_q;
        inflight_d = 1'b0;
        discard_d  = 1'b0;
        enter      = 1'b0;
        if (bus.jump_i) begin
            // A byte granted this cycle belongs to the old stream; mark it for dropping.
            state_d    = FETCH;
            fpc_d      = bus.jump_addr_i & ~32'd3;
            iss_d      = '0;
            rcv_d      = '0;
            valid_d    = 1'b0;
            inflight_d = issue;
            discard_d  = issue;
            enter      = 1'b1;
        end else if (state_q == HOLD) begin
            if (valid_q && !bus.stall_i) begin
                state_d = FETCH;
                fpc_d   = fpc_q + 32'd4;
                iss_d   = '0;
                rcv_d   = '0;
                valid_d = 1'b0;
                enter   = 1'b1;
            end
        end else if (hit_q) begin
            state_d = HOLD;
            pc_d    = fpc_q;
            inst_d  = cword;
            valid_d = 1'b1;
        end else begin
            inflight_d = issue;
            if (issue) begin
                iss_d = iss_q + 3'd1;
            end
            if (inflight_q && !discard_q) begin
                if (rcv_q == 2'd3) begin
                    state_d = HOLD;
                    pc_d    = fpc_q;
                    inst_d  = {bus.mem_din_i, buf_q};
                    valid_d = 1'b1;
                end else begin
                    unique case (rcv_q)
                        2'd0:    buf_d[7:0]   = bus.mem_din_i;
                        2'd1:    buf_d[15:8]  = bus.mem_din_i;
                        default: buf_d[23:16] = bus.mem_din_i;
                    endcase
                    rcv_d = rcv_q + 2'd1;
                end
            end
        end
    end

    // Bus outputs are registered, so they are derived from the next state.
    assign rd_en_d = (state_d == FETCH) && (iss_d != 3'd4) && !hit_d;
    assign a_d     = fpc_d + {29'd0, iss_d};

`ifdef ICACHE_EN
    localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic [31:0]             cdata_q [ICACHE_LINES];
    logic [TAG_W-1:0]        ctag_q  [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] cvalid_q;
    logic [IDX_W-1:0]        lk_idx, cur_idx;
    logic                    fill;

    assign lk_idx  = fpc_d[IDX_W+1:2];
    assign cur_idx = fpc_q[IDX_W+1:2];
    assign hit_d   = enter && cvalid_q[lk_idx] && (ctag_q[lk_idx] == fpc_d[31:IDX_W+2]);
    assign cword   = cdata_q[cur_idx];
    // Only a completed memory fill reaches HOLD from FETCH without a cache hit.
    assign fill    = (state_q == FETCH) && (state_d == HOLD) && !hit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cvalid_q <= '0;
        end else if (rdy && fill) begin
            cvalid_q[cur_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && fill) begin
            cdata_q[cur_idx] <= inst_d;
            ctag_q[cur_idx]  <= fpc_q[31:IDX_W+2];
        end
    end
`else
    assign hit_d = 1'b0;
    assign cword = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            fpc_q      <= RESET_PC;
            iss_q      <= '0;
            rcv_q      <= '0;
            buf_q      <= '0;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
            pc_q       <= '0;
            inst_q     <= '0;
            valid_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            a_q        <= '0;
            hit_q      <= 1'b0;
        end else if (rdy) begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            iss_q      <= iss_d;
            rcv_q      <= rcv_d;
            buf_q      <= buf_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
            rd_en_q    <= rd_en_d;
            a_q        <= a_d;
            hit_q      <= hit_d;
        end
    end

    assign bus.mem_a_o      = a_q;
    assign bus.mem_rd_en_o  = rd_en_q;
    assign bus.pc_o         = pc_q;
    assign bus.inst_o       = inst_q;
    assign bus.inst_valid_o = valid_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: byte-memory model plus a scoreboard of expected pc/instruction pairs.
module tb_if_fetch_unit;
    logic clk;
    logic rst;
    logic rdy;

    if_fetch_unit_if bus_if ();

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .ICACHE_LINES(64)) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .bus(bus_if)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem [0:4095];
    int         checks = 0;
    int         passed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rdy && bus_if.mem_rd_en_o && bus_if.mem_grant_i)
            bus_if.mem_din_i <= mem[bus_if.mem_a_o[11:0]];
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [11:0] i;
        i = a[11:0];
        return {mem[i + 12'd3], mem[i + 12'd2], mem[i + 12'd1], mem[i]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.inst = word_at(a);
        sb.push_back(e);
    endtask

    task automatic wait_valid(input int limit, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < limit) begin
            if (bus_if.inst_valid_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
            n++;
        end
    endtask

    task automatic do_jump(input logic [31:0] a);
        bus_if.jump_i      = 1'b1;
        bus_if.jump_addr_i = a;
        step();
        bus_if.jump_i      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1;
        bus_if.stall_i = 1'b0; bus_if.jump_i = 1'b0;
        bus_if.jump_addr_i = '0; bus_if.mem_grant_i = 1'b1;
        step();
        step();
        checks++;
        if ({bus_if.pc_o, bus_if.inst_o, bus_if.inst_valid_o, bus_if.mem_rd_en_o, bus_if.mem_a_o} !== '0)
            $display("FAIL reset_outputs got pc=%h inst=%h v=%b rd=%b a=%h required all zero",
                     bus_if.pc_o, bus_if.inst_o, bus_if.inst_valid_o, bus_if.mem_rd_en_o, bus_if.mem_a_o);
        else passed++;
    endtask

    task automatic test_basic_fetch();
        exp_t e;
        rst = 1'b0;
        step();
        push_exp(32'h0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus_if.mem_rd_en_o !== 1'b1 || bus_if.mem_a_o !== 32'(i))
                $display("FAIL basic_issue%0d got rd=%b a=%h required rd=1 a=%h",
                         i, bus_if.mem_rd_en_o, bus_if.mem_a_o, 32'(i));
            else passed++;
            step();
        end
        checks++;
        if (bus_if.mem_rd_en_o !== 1'b0 || bus_if.inst_valid_o !== 1'b0)
            $display("FAIL basic_cycle4 got rd=%b v=%b required rd=0 v=0", bus_if.mem_rd_en_o, bus_if.inst_valid_o);
        else passed++;
        step();
        e = sb.pop_front();
        checks++;
        if (bus_if.inst_valid_o !== 1'b1 || bus_if.pc_o !== e.pc || bus_if.inst_o !== e.inst || e.inst !== 32'h00100513)
            $display("FAIL basic_word got v=%b pc=%h inst=%h required v=1 pc=%h inst=00100513",
                     bus_if.inst_valid_o, bus_if.pc_o, bus_if.inst_o, e.pc);
        else passed++;
        step();
        checks++;
        if (bus_if.mem_rd_en_o !== 1'b1 || bus_if.mem_a_o !== 32'h4 || bus_if.inst_valid_o !== 1'b0)
            $display("FAIL basic_next got rd=%b a=%h v=%b required rd=1 a=4 v=0",
                     bus_if.mem_rd_en_o, bus_if.mem_a_o, bus_if.inst_valid_o);
        else passed++;
    endtask

    task automatic test_stall();
        exp_t e;
        int n;
        bit ok;
        logic [31:0] spc, sinst;
        bus_if.stall_i = 1'b1;
        push_exp(32'h4);
        wait_valid(20, n, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || n != 5 || bus_if.pc_o !== e.pc || bus_if.inst_o !== e.inst)
            $display("FAIL stall_word got ok=%b lat=%0d pc=%h inst=%h required lat=5 pc=%h inst=%h",
                     ok, n, bus_if.pc_o, bus_if.inst_o, e.pc, e.inst);
        else passed++;
        spc = bus_if.pc_o;
        sinst = bus_if.inst_o;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (bus_if.inst_valid_o !== 1'b1 || bus_if.mem_rd_en_o !== 1'b0 ||
                bus_if.pc_o !== spc || bus_if.inst_o !== sinst)
                $display("FAIL stall_hold%0d got v=%b rd=%b pc=%h inst=%h required v=1 rd=0 pc=%h inst=%h",
                         k, bus_if.inst_valid_o, bus_if.mem_rd_en_o, bus_if.pc_o, bus_if.inst_o, spc, sinst);
            else passed++;
        end
        bus_if.stall_i = 1'b0;
        step();
        checks++;
        if (bus_if.mem_rd_en_o !== 1'b1 || bus_if.mem_a_o !== 32'h8 || bus_if.inst_valid_o !== 1'b0)
            $display("FAIL stall_release got rd=%b a=%h v=%b required rd=1 a=8 v=0",
                     bus_if.mem_rd_en_o, bus_if.mem_a_o, bus_if.inst_valid_o);
        else passed++;
    endtask

    task automatic test_jump_discard();
        exp_t e;
        int n;
        bit ok;
        step();
        step();
        checks++;
        if (bus_if.mem_a_o !== 32'ha)
            $display("FAIL jump_pre got a=%h required a=0000000a", bus_if.mem_a_o);
        else passed++;
        do_jump(32'h103);
        checks++;
        if (bus_if.mem_rd_en_o !== 1'b1 || bus_if.mem_a_o !== 32'h100 || bus_if.inst_valid_o !== 1'b0)
            $display("FAIL jump_target got rd=%b a=%h v=%b required rd=1 a=100 v=0",
                     bus_if.mem_rd_en_o, bus_if.mem_a_o, bus_if.inst_valid_o);
        else passed++;
        push_exp(32'h100);
        wait_valid(20, n, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || n != 5 || bus_if.pc_o !== e.pc || bus_if.inst_o !== e.inst)
            $display("FAIL jump_word got ok=%b lat=%0d pc=%h inst=%h required lat=5 pc=%h inst=%h",
                     ok, n, bus_if.pc_o, bus_if.inst_o, e.pc, e.inst);
        else passed++;
        step();
    endtask

    task automatic test_jump_in_hold();
        exp_t e;
        int n;
        bit ok;
        bus_if.stall_i = 1'b1;
        do_jump(32'h200);
        push_exp(32'h200);
        wait_valid(20, n, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || bus_if.pc_o !== e.pc || bus_if.inst_o !== e.inst)
            $display("FAIL hold_word got ok=%b pc=%h inst=%h required pc=%h inst=%h",
                     ok, bus_if.pc_o, bus_if.inst_o, e.pc, e.inst);
        else passed++;
        step();
        do_jump(32'h204);
        checks++;
        if (bus_if.inst_valid_o !== 1'b0 || bus_if.mem_rd_en_o !== 1'b1 || bus_if.mem_a_o !== 32'h204)
            $display("FAIL hold_redirect got v=%b rd=%b a=%h required v=0 rd=1 a=204",
                     bus_if.inst_valid_o, bus_if.mem_rd_en_o, bus_if.mem_a_o);
        else passed++;
        push_exp(32'h204);
        wait_valid(20, n, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || bus_if.pc_o !== e.pc || bus_if.inst_o !== e.inst)
            $display("FAIL hold_word2 got ok=%b pc=%h inst=%h required pc=%h inst=%h",
                     ok, bus_if.pc_o, bus_if.inst_o, e.pc, e.inst);
        else passed++;
        bus_if.stall_i = 1'b0;
        step();
    endtask

    task automatic test_grant_gap();
        exp_t e;
        int n;
        bit ok;
        do_jump(32'h40);
        push_exp(32'h40);
        step();
        bus_if.mem_grant_i = 1'b0;
        step();
        step();
        checks++;
        if (bus_if.mem_rd_en_o !== 1'b1 || bus_if.mem_a_o !== 32'h41)
            $display("FAIL gap_addr got rd=%b a=%h required rd=1 a=41", bus_if.mem_rd_en_o, bus_if.mem_a_o);
        else passed++;
        bus_if.mem_grant_i = 1'b1;
        wait_valid(20, n, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || n != 4 || bus_if.pc_o !== e.pc || bus_if.inst_o !== e.inst)
            $display("FAIL gap_word got ok=%b lat=%0d pc=%h inst=%h required lat=4 pc=%h inst=%h",
                     ok, n, bus_if.pc_o, bus_if.inst_o, e.pc, e.inst);
        else passed++;
        step();
    endtask

    task automatic test_rdy_freeze();
        exp_t e;
        int n;
        bit ok;
        logic [33:0] snap;
        do_jump(32'h80);
        push_exp(32'h80);
        step();
        rdy = 1'b0;
        snap = {bus_if.mem_a_o, bus_if.mem_rd_en_o, bus_if.inst_valid_o};
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if ({bus_if.mem_a_o, bus_if.mem_rd_en_o, bus_if.inst_valid_o} !== snap || snap !== {32'h81, 2'b10})
                $display("FAIL rdy_freeze%0d got a=%h rd=%b v=%b required a=81 rd=1 v=0",
                         k, bus_if.mem_a_o, bus_if.mem_rd_en_o, bus_if.inst_valid_o);
            else passed++;
        end
        rdy = 1'b1;
        wait_valid(20, n, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || n != 4 || bus_if.pc_o !== e.pc || bus_if.inst_o !== e.inst)
            $display("FAIL rdy_word got ok=%b lat=%0d pc=%h inst=%h required lat=4 pc=%h inst=%h",
                     ok, n, bus_if.pc_o, bus_if.inst_o, e.pc, e.inst);
        else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int n;
        bit ok;
        do_jump(32'hFFFF_FFF8);
        push_exp(32'hFFFF_FFF8);
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0000_0000);
        for (int k = 0; k < 3; k++) begin
            wait_valid(20, n, ok);
            e = sb.pop_front();
            checks++;
            if (!ok || bus_if.pc_o !== e.pc || bus_if.inst_o !== e.inst)
                $display("FAIL b2b_word%0d got ok=%b pc=%h inst=%h required pc=%h inst=%h",
                         k, ok, bus_if.pc_o, bus_if.inst_o, e.pc, e.inst);
            else passed++;
            step();
        end
    endtask

`ifdef ICACHE_EN
    task automatic test_icache();
        exp_t e;
        int n;
        bit ok;
        do_jump(32'h300);
        checks++;
        if (bus_if.mem_rd_en_o !== 1'b1 || bus_if.mem_a_o !== 32'h300)
            $display("FAIL cache_miss got rd=%b a=%h required rd=1 a=300", bus_if.mem_rd_en_o, bus_if.mem_a_o);
        else passed++;
        push_exp(32'h300);
        wait_valid(20, n, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || bus_if.pc_o !== e.pc || bus_if.inst_o !== e.inst)
            $display("FAIL cache_fill got ok=%b pc=%h inst=%h required pc=%h inst=%h",
                     ok, bus_if.pc_o, bus_if.inst_o, e.pc, e.inst);
        else passed++;
        step();
        do_jump(32'h300);
        checks++;
        if (bus_if.mem_rd_en_o !== 1'b0 || bus_if.inst_valid_o !== 1'b0)
            $display("FAIL cache_hit_rd got rd=%b v=%b required rd=0 v=0", bus_if.mem_rd_en_o, bus_if.inst_valid_o);
        else passed++;
        push_exp(32'h300);
        step();
        e = sb.pop_front();
        checks++;
        if (bus_if.inst_valid_o !== 1'b1 || bus_if.mem_rd_en_o !== 1'b0 ||
            bus_if.pc_o !== e.pc || bus_if.inst_o !== e.inst)
            $display("FAIL cache_hit_word got v=%b rd=%b pc=%h inst=%h required v=1 rd=0 pc=%h inst=%h",
                     bus_if.inst_valid_o, bus_if.mem_rd_en_o, bus_if.pc_o, bus_if.inst_o, e.pc, e.inst);
        else passed++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        do_jump(32'h300);
        checks++;
        if (bus_if.mem_rd_en_o !== 1'b1 || bus_if.mem_a_o !== 32'h300)
            $display("FAIL cache_after_reset got rd=%b a=%h required rd=1 a=300",
                     bus_if.mem_rd_en_o, bus_if.mem_a_o);
        else passed++;
    endtask
`endif

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
        mem[10] = 8'hA5;
        mem[12'h100] = 8'h93; mem[12'h101] = 8'h00; mem[12'h102] = 8'h20; mem[12'h103] = 8'h00;
        bus_if.mem_din_i = '0;
        test_reset();
        test_basic_fetch();
        test_stall();
        test_jump_discard();
        test_jump_in_hold();
        test_grant_gap();
        test_rdy_freeze();
        test_back_to_back();
`ifdef ICACHE_EN
        test_icache();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline; produces the pc/instruction pair that the IF_ID register delivers to the decode stage.
- Reads 32-bit instructions from the byte-wide memory bus as four little-endian byte reads.
- Holds a fetched instruction while decode stalls.
- Redirects on branch/jump requests from EX.

Parameters:
- RESET_PC, 32'h0000_0000, pc fetched first after reset.
- ICACHE_LINES, 64, number of one-word cache lines. Power of 2. Used only with ICACHE_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rdy  in  1  global ready; low freezes all state
- stall_i  in  1  decode/hazard stall; high = held instruction not consumed this edge
- jump_i  in  1  redirect request from EX
- jump_addr_i  in  32  redirect target; bits [1:0] ignored (treated as 0)
- mem_grant_i  in  1  arbiter grants bus this cycle
- mem_din_i  in  8  read byte; valid the cycle after its address was issued with grant
- mem_a_o  out  32  byte address
- mem_rd_en_o  out  1  read request
- pc_o  out  32  pc of held instruction
- inst_o  out  32  held instruction
- inst_valid_o  out  1  pc_o/inst_o valid

Behaviour:
- Reset is rst, synchronous, active-high.
  - Outputs: pc_o=0, inst_o=0, inst_valid_o=0, mem_rd_en_o=0, mem_a_o=0.
  - Internal fetch pc = RESET_PC. State = FETCH. Counters = 0. Discard flag = 0.
  - Reset wins over every other input.
  - Reset mid-fetch drops all partial data.
- rdy=0: no register changes; outputs hold.
- States:
  - FETCH (issue/collect bytes)
  - HOLD (inst_valid_o=1, wait for accept)
- FETCH:
  - Issue counter iss (0..4): while iss<4, drive mem_rd_en_o=1 and mem_a_o=fpc+iss.
  - iss increments only when mem_grant_i=1.
  - A cycle with grant=0 issues nothing; it still drives the address with rd_en=1.
  - Receive side: a byte issued with grant at cycle t is captured at edge t+1 into inst bits [8k+7:8k], where k = receive counter, 0..3.
- FETCH -> HOLD:
  - Taken at the edge where byte 3 is captured.
  - That edge loads inst_o, sets pc_o=fpc and sets inst_valid_o=1.
  - With constant grant, inst_valid_o rises 5 cycles after FETCH entry.
  - mem_rd_en_o=0 once iss=4.
- HOLD:
  - mem_rd_en_o=0.
  - Accept = inst_valid_o & ~stall_i at an edge.
  - On accept: fpc<=fpc+4 (32-bit wrap), inst_valid_o<=0, counters<=0, state<=FETCH. The next cycle issues the new fpc.
  - With stall_i=1: pc_o/inst_o/inst_valid_o stay stable.
- Redirect (jump_i=1 at an edge), in any state:
  - Priority over stall_i and accept.
  - fpc<={jump_addr_i[31:2],2'b00}, inst_valid_o<=0, counters<=0, state<=FETCH.
  - If a granted byte is in flight, set discard=1. The byte arriving next cycle is dropped; discard clears.
  - The next cycle issues the target address; simultaneously returning stale data is never written.
- The 5-cycle latency and no fetch overlap are fixed (non-pipelined fetch).

Optional Feature:
- Macro: ICACHE_EN.
- When defined, the block contains a direct-mapped cache of ICACHE_LINES words.
  - Index = fpc[2+log2(ICACHE_LINES)-1:2]; tag = the remaining upper bits; one valid bit per line.
  - On FETCH entry: on a hit, no memory request is issued (mem_rd_en_o=0). HOLD is entered at the next edge with the cached word, giving 1-cycle latency.
  - On a miss: normal byte fetch. The line is written at the FETCH->HOLD edge.
  - A redirect mid-fill writes nothing.
  - rst clears all valid bits. Lines are never invalidated otherwise.
- When undefined: no cache storage; every fetch uses the memory bus; ICACHE_LINES is unused.

Test Plan:
1. Reset with mem[0..3]=13 05 10 00, grant=1, stall=0 -> mem_a_o 0,1,2,3 in cycles 0-3; cycle 5: inst_valid_o=1, inst_o=32'h00100513, pc_o=0; cycle 6: mem_a_o=4.
2. Hold stall_i=1 for 3 cycles in HOLD -> pc_o/inst_o unchanged, mem_rd_en_o=0; after release, mem_a_o=4 next cycle.
3. jump_i=1 with jump_addr_i=32'h103 while byte 2 is in flight -> next cycle mem_a_o=32'h100; stale byte not written; inst_o=mem[0x100..0x103] word, pc_o=32'h100.
4. mem_grant_i=0 for 2 cycles at byte 1 -> mem_a_o stays at byte 1's address; inst_valid_o rises at cycle 7 with the correct word.
5. rdy=0 for 4 cycles mid-fetch -> no state change; after rdy=1, the fetch completes with the correct word.
6. ICACHE_EN: fetch 0x100, then redirect to 0x100 -> second fetch has mem_rd_en_o=0 and inst_valid_o=1 one cycle after redirect, same word; reset then refetch -> memory access again.
